sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Shared-access controller for a bank of NFLAGS SR flip-flops (one sr_ff per flag, same clk/rst).
- Arbitrates NREQ requesters round-robin and converts each granted set/clear/toggle/read command into a single-cycle, never-invalid (s=r=1 impossible) s/r pulse on the addressed flop.
- Reads back q to confirm the update and returns the completion status to the requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAGS, 8, number of SR flip-flops in the bank.
- IDXW, 3, index width per requester; must satisfy 2^IDXW >= NFLAGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  request per requester; held high until granted.
- req_op  input  2*NREQ  op per requester, slice [2i+1:2i]: 00 READ, 01 SET, 10 CLR, 11 TOGGLE.
- req_idx  input  IDXW*NREQ  flag index per requester, slice [IDXW*i +: IDXW].
- q_vec  input  NFLAGS  q outputs of the flop bank.
- gnt  output  NREQ  one-hot grant, one-cycle pulse.
- s_vec  output  NFLAGS  set inputs to the bank.
- r_vec  output  NFLAGS  reset inputs to the bank.
- busy  output  1  high while a command is in flight (states DRIVE, CHECK).
- done  output  1  one-cycle completion pulse.
- done_id  output  clog2(NREQ)  requester that completed.
- rd_val  output  1  flag value after the operation, valid with done.
- err  output  1  valid with done: readback mismatch or index out of range.

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE, rr_ptr=0, and gnt, s_vec, r_vec, busy, done, done_id, rd_val, err all 0. An in-flight op is abandoned with no done pulse.
- FSM has three states: IDLE -> DRIVE -> CHECK -> IDLE.
- IDLE, at an edge with any req set:
  - Winner is the first set req bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch id, op and idx; gnt[winner]=1 for the next cycle; busy=1; state=DRIVE.
  - Compute expected value from q_vec[idx] sampled at this edge: SET->1, CLR->0, TOGGLE->~q, READ->q.
  - s_vec/r_vec register one-hot at idx: SET or TOGGLE-to-1 -> s only; CLR or TOGGLE-to-0 -> r only; READ -> neither.
  - If idx >= NFLAGS: no s/r bit is driven and a bad flag is recorded.
  - rr_ptr = winner+1 mod NREQ.
- DRIVE (1 cycle): s/r held; the bank captures at the ending edge. At that edge gnt, s_vec and r_vec clear; state=CHECK.
- CHECK (1 cycle), at the ending edge:
  - done=1, done_id=id, rd_val=q_vec[idx] (0 if out of range).
  - err = bad, or q_vec[idx] != expected.
  - busy=0; state=IDLE.
- Latency: req sampled at edge E0, gnt high E0–E1, s/r high E0–E1, done high E2–E3.
- Throughput: next arbitration edge is E3, so one op per 3 cycles.
- Requests arriving while busy are not sampled and wait. A requester may drop req after gnt; dropping it earlier withdraws the request.
- Invariant: s_vec & r_vec == 0 always, and at most one bit of each is set.
- Simultaneous requests: exactly one gnt; the others are served in round-robin order, so a continuously requesting requester waits at most NREQ-1 ops.
- Same-flag back-to-back ops: the second op sees the result of the first, because its expected value is sampled at its own IDLE edge.

Test Plan:
- Reset then SET: rst=1 for 2 cycles, then req0, op=01, idx=3 -> gnt=0001 E0–E1; s_vec=0x08, r_vec=0 E0–E1; done=1, done_id=0, rd_val=1, err=0 E2–E3; q_vec[3]=1.
- Arbitration: req=1111 held with SET to idx 0..3 -> grants in order 0,1,2,3,0 at 3-cycle spacing; gnt always one-hot; rr_ptr wraps 3->0.
- TOGGLE twice on idx 5 from q=0 -> first pulses s_vec=0x20 and returns rd_val=1; second pulses r_vec=0x20 and returns rd_val=0; err=0 both times.
- READ idx 2 with q=1 -> s_vec=r_vec=0 throughout; rd_val=1; err=0. Stuck-bit model forces q_vec[2]=0 on a SET -> err=1.
- Out of range (NFLAGS=6, IDXW=3): idx=7 SET -> no s/r activity; done=1, err=1, rd_val=0.
- Reset mid-op: assert rst during DRIVE -> s_vec, r_vec, gnt, busy go 0 immediately; no done pulse; next request after release is granted in order from requester 0.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin shared access to a bank of SR flops. Each granted
// command becomes a single s or r pulse, followed by a readback that confirms it.
module sr_flag_arbiter #(
   parameter  int NREQ   = 4,
   parameter  int NFLAGS = 8,
   parameter  int IDXW   = 3,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [IDXW*NREQ-1:0] req_idx,
   input  logic [NFLAGS-1:0]    q_vec,
   output logic [NREQ-1:0]      gnt,
   output logic [NFLAGS-1:0]    s_vec,
   output logic [NFLAGS-1:0]    r_vec,
   output logic                 busy,
   output logic                 done,
   output logic [IDW-1:0]       done_id,
   output logic                 rd_val,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
   typedef enum logic [1:0] {OP_READ = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_TOG = 2'b11} op_t;

   typedef struct packed {
      logic [IDW-1:0]  id;
      logic [IDXW-1:0] idx;
      logic            exp;
      logic            bad;
   } cmd_t;

   state_t            state, state_n;
   logic [IDW-1:0]    rr_ptr, rr_ptr_n;
   cmd_t              cmd, cmd_n;
   logic [NREQ-1:0]   gnt_n;
   logic [NFLAGS-1:0] s_n, r_n;
   logic              busy_n, done_n, rd_n, err_n;
   logic [IDW-1:0]    done_id_n;

   logic              found;
   logic [IDW-1:0]    win;
   logic [1:0]        w_op;
   logic [IDXW-1:0]   w_idx;
   int                p;

   // First requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      w_op  = '0;
      w_idx = '0;
      p     = 0;
      for (int k = 0; k < NREQ; k++) begin
         p = (int'(rr_ptr) + k) % NREQ;
         if (!found && req[p]) begin
            found = 1'b1;
            win   = IDW'(p);
            w_op  = req_op[2*p +: 2];
            w_idx = req_idx[IDXW*p +: IDXW];
         end
      end
   end

   // One flag decoder shared by arbitration (new index) and readback (latched index).
   logic [IDXW-1:0]   sel_idx;
   logic [NFLAGS-1:0] sel_oh;
   logic              sel_q;

   always_comb begin
      sel_idx = (state == IDLE) ? w_idx : cmd.idx;
      sel_oh  = '0;
      sel_q   = 1'b0;
      for (int f = 0; f < NFLAGS; f++) begin
         if (sel_idx == IDXW'(f)) begin
            sel_oh[f] = 1'b1;
            sel_q     = q_vec[f];
         end
      end
   end

   logic tgt;

   always_comb begin
      state_n   = state;
      rr_ptr_n  = rr_ptr;
      cmd_n     = cmd;
      gnt_n     = '0;
      s_n       = '0;
      r_n       = '0;
      busy_n    = busy;
      done_n    = 1'b0;
      done_id_n = done_id;
      rd_n      = rd_val;
      err_n     = err;
      tgt       = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               case (op_t'(w_op))
                  OP_SET:  tgt = 1'b1;
                  OP_CLR:  tgt = 1'b0;
                  OP_TOG:  tgt = ~sel_q;
                  default: tgt = sel_q;
               endcase
               cmd_n.id   = win;
               cmd_n.idx  = w_idx;
               cmd_n.exp  = tgt;
               cmd_n.bad  = ~|sel_oh;
               gnt_n[win] = 1'b1;
               // sel_oh is empty for an out-of-range index, so nothing is pulsed.
               if (op_t'(w_op) != OP_READ) begin
                  s_n = tgt ? sel_oh : '0;
                  r_n = tgt ? '0 : sel_oh;
               end
               rr_ptr_n = (int'(win) == NREQ-1) ? '0 : win + IDW'(1);
               busy_n   = 1'b1;
               state_n  = DRIVE;
            end
         end
         DRIVE: state_n = CHECK;
         CHECK: begin
            done_n    = 1'b1;
            done_id_n = cmd.id;
            rd_n      = sel_q;
            err_n     = cmd.bad | (sel_q != cmd.exp);
            busy_n    = 1'b0;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         cmd     <= '0;
         gnt     <= '0;
         s_vec   <= '0;
         r_vec   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         rd_val  <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         rr_ptr  <= rr_ptr_n;
         cmd     <= cmd_n;
         gnt     <= gnt_n;
         s_vec   <= s_n;
         r_vec   <= r_n;
         busy    <= busy_n;
         done    <= done_n;
         done_id <= done_id_n;
         rd_val  <= rd_n;
         err     <= err_n;
      end
   end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: SR flop bank with optional stuck-at-0 bits, plus a
// reference model of flag contents and round-robin order.
module tb_sr_flag_arbiter;
   localparam int NREQ = 4, NFLAGS = 6, IDXW = 3, IDW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    req_op;
   logic [IDXW*NREQ-1:0] req_idx;
   logic [NFLAGS-1:0]    q_vec, bank, stuck;
   logic [NREQ-1:0]      gnt;
   logic [NFLAGS-1:0]    s_vec, r_vec;
   logic                 busy, done, rd_val, err;
   logic [IDW-1:0]       done_id;

   int checks = 0, errors = 0;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
      .q_vec(q_vec), .gnt(gnt), .s_vec(s_vec), .r_vec(r_vec), .busy(busy),
      .done(done), .done_id(done_id), .rd_val(rd_val), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) bank <= '0;
      else     bank <= (bank | s_vec) & ~r_vec;
   assign q_vec = bank & ~stuck;

   // Observation of one transaction: samples after E0, E1 and E2.
   typedef struct packed {
      logic [NREQ-1:0]   g0;
      logic [NFLAGS-1:0] s0, r0;
      logic              b0, d0;
      logic [NREQ-1:0]   g1;
      logic [NFLAGS-1:0] s1, r1;
      logic              b1, d1, d2, b2;
      logic [IDW-1:0]    id;
      logic              rd, er, inv;
   } txn_t;

   int                m_ptr;
   logic [NFLAGS-1:0] m_flag;
   logic [1:0]        t_op  [NREQ];
   logic [IDXW-1:0]   t_idx [NREQ];

   function automatic string fmt(input txn_t t);
      return $sformatf("gnt=%b/%b s=%h/%h r=%h/%h busy=%b%b%b done=%b%b%b id=%0d rd=%b err=%b inv=%b",
         t.g0, t.g1, t.s0, t.s1, t.r0, t.r1, t.b0, t.b1, t.b2, t.d0, t.d1, t.d2, t.id, t.rd, t.er, t.inv);
   endfunction

   function automatic logic inv_ok();
      return ((s_vec & r_vec) == '0) && $onehot0(s_vec) && $onehot0(r_vec) && $onehot0(gnt);
   endfunction

   task automatic set_req(input int i, input logic [1:0] op, input logic [IDXW-1:0] ix);
      t_op[i] = op;
      t_idx[i] = ix;
      req_op[2*i +: 2] = op;
      req_idx[IDXW*i +: IDXW] = ix;
   endtask

   // Expected transaction for the request mask seen at the arbitration edge; advances the model.
   function automatic txn_t predict(input logic [NREQ-1:0] mask);
      txn_t e;
      int w, ix;
      logic [1:0] op;
      logic qr, tv, bad;
      e = '0;
      w = -1;
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && mask[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      op  = t_op[w];
      ix  = int'(t_idx[w]);
      bad = ix >= NFLAGS;
      qr  = bad ? 1'b0 : (m_flag[ix] & ~stuck[ix]);
      case (op)
         2'b01:   tv = 1'b1;
         2'b10:   tv = 1'b0;
         2'b11:   tv = ~qr;
         default: tv = qr;
      endcase
      e.g0 = NREQ'(1) << w;
      e.b0 = 1'b1;
      e.b1 = 1'b1;
      e.d2 = 1'b1;
      e.id = IDW'(w);
      e.inv = 1'b1;
      if (!bad && op != 2'b00) begin
         if (tv) e.s0[ix] = 1'b1;
         else    e.r0[ix] = 1'b1;
         m_flag[ix] = tv;
      end
      e.rd = bad ? 1'b0 : (m_flag[ix] & ~stuck[ix]);
      e.er = bad || (e.rd != tv);
      m_ptr = (w + 1) % NREQ;
      return e;
   endfunction

   // Runs one transaction from an idle DUT; 'late' requests are raised while busy.
   task automatic run_txn(input logic [NREQ-1:0] late, output txn_t o);
      o = '0;
      o.inv = 1'b1;
      @(posedge clk); @(negedge clk);
      o.g0 = gnt; o.s0 = s_vec; o.r0 = r_vec; o.b0 = busy; o.d0 = done;
      o.inv &= inv_ok();
      req = (req & ~gnt) | late;
      @(posedge clk); @(negedge clk);
      o.g1 = gnt; o.s1 = s_vec; o.r1 = r_vec; o.b1 = busy; o.d1 = done;
      o.inv &= inv_ok();
      @(posedge clk); @(negedge clk);
      o.d2 = done; o.b2 = busy; o.id = done_id; o.rd = rd_val; o.er = err;
      o.inv &= inv_ok();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
      m_flag = '0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      v = 32'({gnt, s_vec, r_vec, busy, done, done_id, rd_val, err});
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_outputs: got %h need 0", v); end
      @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
      m_flag = '0;
   endtask

   task automatic test_set();
      txn_t e, o;
      set_req(0, 2'b01, 3'd3);
      req = 4'b0001;
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL set_idx3: got %s need %s", fmt(o), fmt(e)); end
      checks++;
      if (o.s0 !== 6'h08 || o.rd !== 1'b1 || q_vec[3] !== 1'b1) begin
         errors++; $display("FAIL set_idx3_const: got s=%h rd=%b q3=%b need s=08 rd=1 q3=1", o.s0, o.rd, q_vec[3]);
      end
   endtask

   task automatic test_arbitration();
      txn_t e, o;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, IDXW'(i));
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         e = predict(req);
         run_txn('0, o);
         checks++;
         if (o !== e) begin errors++; $display("FAIL arb_%0d: got %s need %s", n, fmt(o), fmt(e)); end
         checks++;
         if (o.g0 !== (NREQ'(1) << (n % NREQ))) begin
            errors++; $display("FAIL arb_order_%0d: got gnt=%b need requester %0d", n, o.g0, n % NREQ);
         end
         req = 4'b1111;
      end
      req = '0;
   endtask

   task automatic test_toggle();
      txn_t e, o;
      set_req(1, 2'b11, 3'd5);
      for (int n = 0; n < 2; n++) begin
         req = 4'b0010;
         e = predict(req);
         run_txn('0, o);
         checks++;
         if (o !== e) begin errors++; $display("FAIL toggle_%0d: got %s need %s", n, fmt(o), fmt(e)); end
         checks++;
         if ((n == 0 && (o.s0 !== 6'h20 || o.r0 !== 6'h00 || o.rd !== 1'b1 || o.er !== 1'b0)) ||
             (n == 1 && (o.s0 !== 6'h00 || o.r0 !== 6'h20 || o.rd !== 1'b0 || o.er !== 1'b0))) begin
            errors++; $display("FAIL toggle_const_%0d: got s=%h r=%h rd=%b err=%b", n, o.s0, o.r0, o.rd, o.er);
         end
      end
   endtask

   task automatic test_read_stuck();
      txn_t e, o;
      set_req(2, 2'b01, 3'd2);
      req = 4'b0100;
      e = predict(req);
      run_txn('0, o);
      set_req(2, 2'b00, 3'd2);
      req = 4'b0100;
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL read_idx2: got %s need %s", fmt(o), fmt(e)); end
      checks++;
      if (o.s0 !== '0 || o.r0 !== '0 || o.rd !== 1'b1 || o.er !== 1'b0) begin
         errors++; $display("FAIL read_const: got s=%h r=%h rd=%b err=%b need 0 0 1 0", o.s0, o.r0, o.rd, o.er);
      end
      set_req(2, 2'b10, 3'd2);
      req = 4'b0100;
      e = predict(req);
      run_txn('0, o);
      stuck = 6'b000100;
      set_req(2, 2'b01, 3'd2);
      req = 4'b0100;
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e || o.er !== 1'b1) begin errors++; $display("FAIL stuck_set: got %s need %s", fmt(o), fmt(e)); end
      stuck = '0;
   endtask

   task automatic test_out_of_range();
      txn_t e, o;
      set_req(3, 2'b01, 3'd7);
      req = 4'b1000;
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL oor_idx7: got %s need %s", fmt(o), fmt(e)); end
      checks++;
      if (o.s0 !== '0 || o.r0 !== '0 || o.d2 !== 1'b1 || o.er !== 1'b1 || o.rd !== 1'b0) begin
         errors++; $display("FAIL oor_const: got s=%h r=%h done=%b err=%b rd=%b", o.s0, o.r0, o.d2, o.er, o.rd);
      end
   endtask

   task automatic test_back_to_back();
      txn_t e, o;
      set_req(0, 2'b11, 3'd4);
      set_req(1, 2'b11, 3'd4);
      req = 4'b0001;
      e = predict(req);
      run_txn(4'b0010, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_first: got %s need %s", fmt(o), fmt(e)); end
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e || o.r0 !== 6'h10) begin errors++; $display("FAIL b2b_second: got %s need %s", fmt(o), fmt(e)); end
   endtask

   task automatic test_random();
      txn_t e, o;
      logic [NREQ-1:0] add, late;
      for (int it = 0; it < 40; it++) begin
         add = NREQ'($urandom) & ~req;
         if ((req | add) == '0) add = NREQ'(1) << $urandom_range(0, NREQ-1);
         for (int i = 0; i < NREQ; i++)
            if (add[i]) set_req(i, 2'($urandom_range(0, 3)), IDXW'($urandom_range(0, 7)));
         req = req | add;
         late = NREQ'($urandom) & ~req;
         for (int i = 0; i < NREQ; i++)
            if (late[i]) set_req(i, 2'($urandom_range(0, 3)), IDXW'($urandom_range(0, 7)));
         e = predict(req);
         run_txn(late, o);
         checks++;
         if (o !== e) begin errors++; $display("FAIL rand_%0d: got %s need %s", it, fmt(o), fmt(e)); end
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      txn_t e, o;
      logic [31:0] v;
      logic seen;
      do_reset();
      set_req(2, 2'b01, 3'd0);
      req = 4'b0100;
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e) begin errors++; $display("FAIL midop_pre: got %s need %s", fmt(o), fmt(e)); end
      set_req(0, 2'b01, 3'd1);
      req = 4'b0001;
      @(posedge clk); @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || s_vec !== 6'h02 || busy !== 1'b1) begin
         errors++; $display("FAIL midop_drive: got gnt=%b s=%h busy=%b need 0001 02 1", gnt, s_vec, busy);
      end
      #2 rst = 1'b1;
      #1;
      v = 32'({gnt, s_vec, r_vec, busy});
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL midop_async_clear: got %h need 0", v); end
      req = '0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= done | busy;
      end
      rst = 1'b0;
      m_ptr = 0;
      m_flag = '0;
      repeat (2) begin
         @(negedge clk);
         seen |= done | busy;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_done: got activity=%b need 0", seen); end
      set_req(1, 2'b10, 3'd0);
      set_req(3, 2'b01, 3'd5);
      req = 4'b1010;
      e = predict(req);
      run_txn('0, o);
      checks++;
      if (o !== e || o.g0 !== 4'b0010) begin errors++; $display("FAIL midop_after: got %s need %s", fmt(o), fmt(e)); end
      req = '0;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      req_op = '0;
      req_idx = '0;
      stuck = '0;
      m_ptr = 0;
      m_flag = '0;
      for (int i = 0; i < NREQ; i++) begin t_op[i] = '0; t_idx[i] = '0; end
      test_reset();
      test_set();
      test_arbitration();
      test_toggle();
      test_read_stuck();
      test_out_of_range();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
